// File: rtl/noc_pkg.sv
// Shared flit type, FSM encoding and default sizing for the NoC VC input port.
package noc_pkg;
    localparam int DATA_WIDTH_DEF   = 512;
    localparam int VC_NUM_DEF       = 4;
    localparam int VC_DEPTH_DEF     = 16;
    localparam int PRIO_WIDTH_DEF   = 2;
    localparam int PKT_ID_WIDTH_DEF = 8;
    localparam int AGE_LIMIT_DEF    = 64;

    localparam int VC_IDX_W = $clog2(VC_NUM_DEF);
    localparam int CNT_W    = $clog2(VC_DEPTH_DEF) + 1;

    typedef struct packed {
        logic                        last;
        logic [PRIO_WIDTH_DEF-1:0]   prio;
        logic [VC_IDX_W-1:0]         vc;
        logic [PKT_ID_WIDTH_DEF-1:0] pkt_id;
        logic [DATA_WIDTH_DEF-1:0]   data;
    } flit_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } fsm_state_t;
endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC flit FIFO with head output, occupancy and full/empty; head visible the cycle after the write edge.
// No backpressure: writes while full are ignored (the port flags them), reads while empty are ignored.
module noc_vc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_vld,
    input  logic [WIDTH-1:0]       i_wr_dat,
    input  logic                   i_rd_en,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign o_full     = (r_count == (PW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_wr_ok    = i_wr_vld && !o_full;
    assign w_rd_ok    = i_rd_en && !o_empty;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage is left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/noc_vc_input_port.sv
// NoC input port: per-VC FIFOs, prio/round-robin/age arbitration, wormhole lock; NOC_PORT_PERF_EN adds perf counters.
// Write edge t -> out_valid at t+1; output register and all out_* hold while out_valid && !out_ready.
module noc_vc_input_port
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int VC_NUM       = VC_NUM_DEF,
    parameter int VC_DEPTH     = VC_DEPTH_DEF,
    parameter int PRIO_WIDTH   = PRIO_WIDTH_DEF,
    parameter int PKT_ID_WIDTH = PKT_ID_WIDTH_DEF,
    parameter int AGE_LIMIT    = AGE_LIMIT_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    input  logic [$clog2(VC_NUM)-1:0]               in_vc,
    input  logic [PRIO_WIDTH-1:0]                   in_prio,
    input  logic [PKT_ID_WIDTH-1:0]                 in_pkt_id,
    input  logic                                    in_last,
    input  logic [DATA_WIDTH-1:0]                   in_data,
    output logic [VC_NUM-1:0]                       credit_ret,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(VC_NUM)-1:0]               out_vc,
    output logic [PRIO_WIDTH-1:0]                   out_prio,
    output logic [PKT_ID_WIDTH-1:0]                 out_pkt_id,
    output logic                                    out_last,
    output logic [DATA_WIDTH-1:0]                   out_data,
    output logic [VC_NUM*($clog2(VC_DEPTH)+1)-1:0]  vc_count,
    output logic                                    port_busy,
    output logic                                    overflow_err,
    output logic [VC_NUM*32-1:0]                    perf_flits
);
    localparam int VW = $clog2(VC_NUM);
    localparam int CW = $clog2(VC_DEPTH) + 1;
    localparam int AW = $clog2(AGE_LIMIT + 1);

    typedef struct packed {
        logic                    last;
        logic [PRIO_WIDTH-1:0]   prio;
        logic [VW-1:0]           vc;
        logic [PKT_ID_WIDTH-1:0] pkt_id;
        logic [DATA_WIDTH-1:0]   data;
    } port_flit_t;

    localparam int FW = $bits(port_flit_t);

    port_flit_t            w_in_flit;
    port_flit_t            w_sel_flit;
    port_flit_t            r_out_flit;
    port_flit_t            w_head [VC_NUM];
    logic [VC_NUM-1:0]     w_full, w_empty, w_deq_oh, r_credit;
    logic [AW-1:0]         r_age [VC_NUM];
    fsm_state_t            r_state;
    logic [VW-1:0]         r_lock_vc, r_rr_ptr, w_sel_vc, w_starve_vc, w_rr_vc, w_rr_idx;
    logic                  w_starve_vld, w_rr_vld, w_sel_vld, w_load, w_deq;
    logic                  r_out_valid, r_overflow;
    logic [PRIO_WIDTH-1:0] w_max_prio;

    assign w_in_flit = '{last: in_last, prio: in_prio, vc: in_vc, pkt_id: in_pkt_id, data: in_data};

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        logic [CW-1:0] w_count;
        noc_vc_fifo #(.WIDTH(FW), .DEPTH(VC_DEPTH)) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_vld   (in_valid && (in_vc == VW'(v))),
            .i_wr_dat   (w_in_flit),
            .i_rd_en    (w_deq_oh[v]),
            .o_head_dat (w_head[v]),
            .o_count    (w_count),
            .o_full     (w_full[v]),
            .o_empty    (w_empty[v])
        );
        assign vc_count[v*CW +: CW] = w_count;
    end

    always_comb begin
        w_starve_vld = 1'b0;
        w_starve_vc  = '0;
        w_max_prio   = '0;
        w_rr_vld     = 1'b0;
        w_rr_vc      = '0;
        w_rr_idx     = '0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            if (!w_empty[i] && (r_age[i] >= AW'(AGE_LIMIT))) begin
                w_starve_vld = 1'b1;
                w_starve_vc  = VW'(i);
            end
        end
        for (int i = 0; i < VC_NUM; i++) begin
            if (!w_empty[i] && (w_head[i].prio > w_max_prio)) w_max_prio = w_head[i].prio;
        end
        // Scan downward so the surviving match is the one nearest rr_ptr.
        for (int k = VC_NUM - 1; k >= 0; k--) begin
            w_rr_idx = VW'((int'(r_rr_ptr) + k) % VC_NUM);
            if (!w_empty[w_rr_idx] && (w_head[w_rr_idx].prio == w_max_prio)) begin
                w_rr_vld = 1'b1;
                w_rr_vc  = w_rr_idx;
            end
        end
    end

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_vc  = '0;
        if (r_state == ST_LOCKED) begin
            w_sel_vld = !w_empty[r_lock_vc];
            w_sel_vc  = r_lock_vc;
        end else if (w_starve_vld) begin
            w_sel_vld = 1'b1;
            w_sel_vc  = w_starve_vc;
        end else begin
            w_sel_vld = w_rr_vld;
            w_sel_vc  = w_rr_vc;
        end
    end

    assign w_sel_flit = w_head[w_sel_vc];
    assign w_load     = !r_out_valid || out_ready;
    assign w_deq      = w_load && w_sel_vld;

    always_comb begin
        w_deq_oh = '0;
        for (int i = 0; i < VC_NUM; i++) w_deq_oh[i] = w_deq && (w_sel_vc == VW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lock_vc   <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_credit    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_credit <= w_deq_oh;
            if (in_valid && w_full[in_vc]) r_overflow <= 1'b1;
            if (w_load) r_out_valid <= w_deq;
            if (w_deq) begin
                r_out_flit <= w_sel_flit;
                if (w_sel_flit.last) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_state   <= ST_LOCKED;
                    r_lock_vc <= w_sel_vc;
                end
                if (r_state == ST_IDLE)
                    r_rr_ptr <= (w_sel_vc == VW'(VC_NUM - 1)) ? '0 : w_sel_vc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VC_NUM; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                if (w_empty[i] || w_deq_oh[i]) r_age[i] <= '0;
                else if (r_age[i] != AW'(AGE_LIMIT)) r_age[i] <= r_age[i] + 1'b1;
            end
        end
    end

`ifdef NOC_PORT_PERF_EN
    logic [31:0] r_perf [VC_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VC_NUM; i++) r_perf[i] <= '0;
        end else begin
            for (int i = 0; i < VC_NUM; i++) if (w_deq_oh[i]) r_perf[i] <= r_perf[i] + 32'd1;
        end
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_perf
        assign perf_flits[v*32 +: 32] = r_perf[v];
    end
`else
    assign perf_flits = '0;
`endif

    assign credit_ret   = r_credit;
    assign out_valid    = r_out_valid;
    assign out_vc       = r_out_flit.vc;
    assign out_prio     = r_out_flit.prio;
    assign out_pkt_id   = r_out_flit.pkt_id;
    assign out_last     = r_out_flit.last;
    assign out_data     = r_out_flit.data;
    assign port_busy    = !(&w_empty) || r_out_valid;
    assign overflow_err = r_overflow;
endmodule
